uart_rx: RTL and testbench

- Receive half of the UART. Consumes the serial line produced by the transmit path (start, DATA_WIDTH data bits LSB first, optional parity, stop).
- Recovers frames by oversampling and presents the parallel word with a one-cycle valid pulse and error flags.
- Runs on a clock that is PRESCALE times the bit rate.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-word outputs of the UART receiver
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  rx;
  logic                  par_en;
  logic                  par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  modport master (
    output rx, par_en, par_typ, prescale,
    input  p_data, data_valid, par_err, stp_err, busy
  );
  modport slave (
    input  rx, par_en, par_typ, prescale,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; define UART_RX_MAJORITY_EN for 3-sample majority voting
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  uart_rx_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q;
  logic                  rx_meta_q, rx_s_q;
  logic [PRESCALE_W-1:0] edge_cnt_q, prescale_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  par_en_q, par_typ_q, par_bad_q;
  logic [DATA_WIDTH-1:0] shift_q, p_data_q;
  logic                  data_valid_q, par_err_q, stp_err_q, busy_q;
  logic [PRESCALE_W-1:0] half, dec_pt;
  logic                  wrap, dec, bit_v, frame_ok;
  assign half = prescale_q >> 1;
  assign wrap = edge_cnt_q == prescale_q - 1'b1;
`ifdef UART_RX_MAJORITY_EN
  logic s0_q, s1_q;
  assign dec_pt = half + 1'b1;
  assign bit_v  = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
  // capture the two early votes; the third is the live sample at the decision point
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (edge_cnt_q == half - 1'b1) s0_q <= rx_s_q;
      if (edge_cnt_q == half) s1_q <= rx_s_q;
    end
`else
  assign dec_pt = half;
  assign bit_v  = rx_s_q;
`endif
  assign dec      = edge_cnt_q == dec_pt;
  assign frame_ok = bit_v & ~(par_en_q & par_bad_q);
  // two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  // frame FSM; STOP decides early so a start edge right at the stop-bit end is not missed
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      edge_cnt_q   <= wrap ? '0 : edge_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          busy_q     <= ~rx_s_q;
          edge_cnt_q <= '0;
          if (!rx_s_q) begin
            state_q    <= START;
            edge_cnt_q <= PRESCALE_W'(1);
            bit_cnt_q  <= '0;
            par_bad_q  <= 1'b0;
            prescale_q <= bus.prescale;
            par_en_q   <= bus.par_en;
            par_typ_q  <= bus.par_typ;
          end
        end
        START:
          if (dec && bit_v) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            edge_cnt_q <= '0;
          end else if (wrap) state_q <= DATA;
        DATA: begin
          if (dec) shift_q[bit_cnt_q] <= bit_v;
          if (wrap) begin
            bit_cnt_q <= bit_cnt_q == LAST ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST) state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (dec) par_bad_q <= bit_v ^ (^shift_q) ^ par_typ_q;
          if (wrap) state_q <= STOP;
        end
        STOP:
          if (dec) begin
            stp_err_q    <= ~bit_v;
            par_err_q    <= par_en_q & par_bad_q;
            data_valid_q <= frame_ok;
            if (frame_ok) p_data_q <= shift_q;
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
          end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames checked cycle by cycle against a frame-level timing model
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();
  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int            cyc;
    logic          dv, pe, se;
    logic [DW-1:0] d;
  } ev_t;
  ev_t           q[$];
  logic [DW-1:0] exp_pdata = '0;
  int            cyc = 0, checks = 0, errors = 0;
  int            last_dv_cyc = -1, dv_count = 0, pe_count = 0, se_count = 0;
  int            k;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : cmp
    logic edv, epe, ese;
    if (rst_n) begin
      edv = 1'b0;
      epe = 1'b0;
      ese = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        edv = q[0].dv;
        epe = q[0].pe;
        ese = q[0].se;
        if (q[0].dv) exp_pdata = q[0].d;
        void'(q.pop_front());
      end
      checks++;
      if ({bus.data_valid, bus.par_err, bus.stp_err, bus.p_data} !== {edv, epe, ese, exp_pdata}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got dv=%b pe=%b se=%b p_data=%h expected dv=%b pe=%b se=%b p_data=%h",
                 cyc, bus.data_valid, bus.par_err, bus.stp_err, bus.p_data, edv, epe, ese, exp_pdata);
      end
      if (bus.data_valid === 1'b1) begin
        last_dv_cyc = cyc;
        dv_count++;
      end
      if (bus.par_err === 1'b1) pe_count++;
      if (bus.stp_err === 1'b1) se_count++;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dv", bus.data_valid, 0);
    chk("rst_pe", bus.par_err, 0);
    chk("rst_se", bus.stp_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pdata", bus.p_data, 0);
    q.delete();
    exp_pdata = '0;
    bus.rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input int p,
                      input logic bad_par, input logic stop_v, input int gap, input int abort_bit,
                      output int k_o);
    int   nb, kk;
    logic par;
    ev_t  e;
    nb           = 2 + DW + int'(pe);
    bus.par_en   = pe;
    bus.par_typ  = pt;
    bus.prescale = p[PW-1:0];
    par          = (^d) ^ pt ^ bad_par;
    kk           = cyc;
    k_o          = kk;
    for (int b = 0; b < nb; b++) begin
      logic v;
      v = (b == 0) ? 1'b0 : (b <= DW) ? d[b-1] : (pe && b == DW + 1) ? par : stop_v;
      if (b == nb - 1) begin
        e.cyc = kk + 3 + (1 + DW + int'(pe)) * p + p / 2 + MAJ;
        e.se  = ~stop_v;
        e.pe  = pe & bad_par;
        e.dv  = ~e.se & ~e.pe;
        e.d   = d;
        q.push_back(e);
      end
      bus.rx = v;
      if (b == abort_bit) begin
        tick(p / 2);
        do_reset();
        return;
      end
      tick(p);
    end
    bus.rx = 1'b1;
    tick(gap);
  endtask
  initial begin
    bus.rx       = 1'b1;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    bus.prescale = PW'(8);
    tick(3);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pdata", bus.p_data, 0);
    chk("reset_dv", bus.data_valid, 0);
    rst_n = 1'b1;
    tick(2);
    send(8'hA5, 1'b0, 1'b0, 8, 1'b0, 1'b1, 16, -1, k);
    chk("a5_pdata", bus.p_data, 8'hA5);
    chk("a5_latency", last_dv_cyc - k, 79 + MAJ);
    chk("a5_dv_count", dv_count, 1);
    chk("a5_busy_low", bus.busy, 0);
    send(8'h03, 1'b1, 1'b0, 8, 1'b0, 1'b1, 8, -1, k);
    send(8'h03, 1'b1, 1'b0, 8, 1'b1, 1'b1, 8, -1, k);
    chk("par_pe_count", pe_count, 1);
    chk("par_dv_count", dv_count, 2);
    chk("par_pdata_hold", bus.p_data, 8'h03);
    send(8'h5A, 1'b0, 1'b0, 16, 1'b0, 1'b0, 16, -1, k);
    chk("stp_se_count", se_count, 1);
    chk("stp_dv_count", dv_count, 2);
    send(8'h11, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, -1, k);
    chk("stp_next_pdata", bus.p_data, 8'h11);
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    chk("glitch_busy_high", bus.busy, 1);
    tick(32);
    chk("glitch_busy_low", bus.busy, 0);
    chk("glitch_dv_count", dv_count, 3);
    send(8'hFF, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, -1, k);
    chk("glitch_next_pdata", bus.p_data, 8'hFF);
    send(8'h00, 1'b1, 1'b1, 32, 1'b0, 1'b1, 0, -1, k);
    send(8'hFF, 1'b1, 1'b1, 32, 1'b0, 1'b1, 0, -1, k);
    send(8'h81, 1'b1, 1'b1, 32, 1'b0, 1'b1, 32, -1, k);
    chk("b2b_dv_count", dv_count, 7);
    chk("b2b_pdata", bus.p_data, 8'h81);
    send(8'h77, 1'b0, 1'b0, 16, 1'b0, 1'b1, 0, 5, k);
    send(8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b1, 16, -1, k);
    chk("rst_next_pdata", bus.p_data, 8'h3C);
    chk("rst_next_dv_count", dv_count, 8);
    for (int i = 0; i < 40; i++) begin
      int   p;
      logic sv;
      p  = 8 << $urandom_range(0, 2);
      sv = $urandom_range(0, 7) != 0;
      send(DW'($urandom), 1'($urandom), 1'($urandom), p, $urandom_range(0, 5) == 0, sv,
           sv ? $urandom_range(0, p) : p, -1, k);
    end
    tick(40);
    chk("all_events_seen", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
